// File: rtl/clk_phase_pkg.sv
// -----------------------------------------------------------------------------
// clk_phase_pkg
//   Shared definitions for the 6502/ANTIC-style phase clock generator:
//   default parameter values, the phase tuple type and the cycle decode
//   that maps a position inside the phi0 period onto the phase outputs.
//   The decode function is the single definition of the phase waveforms and
//   is used both by the generator and by its reference model.
// -----------------------------------------------------------------------------
package clk_phase_pkg;

  localparam int unsigned DIV_DEFAULT          = 32'd56;
  localparam int unsigned NONOVL_DEFAULT       = 32'd2;
  localparam int unsigned LOCK_PERIODS_DEFAULT = 32'd4;

  // One bit per derived phase clock.
  typedef struct packed {
    logic phi0;
    logic phi1;
    logic phi2;
    logic fphi0;
  } phase_t;

  // Decode a period position cnt (0..div-1) into the phase levels.
  //   phi0  : first half of the period
  //   phi2  : first half, minus a leading dead-band of nonovl cycles
  //   phi1  : second half, minus a leading dead-band of nonovl cycles
  //   fphi0 : four sub-periods per phi0 period, high in the first half of each
  function automatic phase_t phase_decode(input int unsigned cnt,
                                          input int unsigned div,
                                          input int unsigned nonovl);
    phase_t      p;
    int unsigned h;
    int unsigned q;
    h       = div / 32'd2;
    q       = div / 32'd4;
    p.phi0  = (cnt < h);
    p.phi2  = (cnt >= nonovl) && (cnt <= (h - 32'd1));
    p.phi1  = (cnt >= (h + nonovl)) && (cnt <= (div - 32'd1));
    p.fphi0 = ((cnt % q) < (q / 32'd2));
    return p;
  endfunction

endpackage

// File: rtl/clk_phase_lock_ctr.sv
// -----------------------------------------------------------------------------
// clk_phase_lock_ctr
//   Counts completed phi0 periods after reset and raises locked once
//   LOCK_PERIODS of them have elapsed. The count saturates so locked stays
//   set until the next reset.
//
// Ports
//   clk100  in   system clock
//   rst     in   synchronous active-high reset
//   wrap    in   the period counter wraps DIV-1 -> 0 on this edge
//   locked  out  registered lock flag, valid in the cycle the final wrap lands
// -----------------------------------------------------------------------------
module clk_phase_lock_ctr
  import clk_phase_pkg::*;
#(
  parameter int unsigned LOCK_PERIODS = LOCK_PERIODS_DEFAULT
) (
  input  logic clk100,
  input  logic rst,
  input  logic wrap,
  output logic locked
);

  localparam int unsigned LCW = $clog2(LOCK_PERIODS + 32'd1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_PERIODS);

  logic [LCW-1:0] lock_cnt_r;
  logic [LCW-1:0] lock_nxt_s;

  if (LOCK_PERIODS < 32'd1) begin : g_bad_lock
    $error("clk_phase_lock_ctr: LOCK_PERIODS must be at least 1");
  end

  // Next lock count: advance on a wrap, stop at LOCK_MAX.
  always_comb begin
    lock_nxt_s = lock_cnt_r;
    if (wrap && (lock_cnt_r < LOCK_MAX)) begin
      lock_nxt_s = lock_cnt_r + LCW'(1);
    end else begin
      lock_nxt_s = lock_cnt_r;
    end
  end

  // Lock counter and flag; the flag is set on the same edge the last wrap
  // lands so it lines up with cnt returning to 0.
  always_ff @(posedge clk100) begin
    if (rst) begin
      lock_cnt_r <= {LCW{1'b0}};
      locked     <= 1'b0;
    end else begin
      lock_cnt_r <= lock_nxt_s;
      locked     <= (lock_nxt_s == LOCK_MAX);
    end
  end

endmodule

// File: rtl/clk_phase_gen.sv
// -----------------------------------------------------------------------------
// clk_phase_gen
//   Derives the CPU clock set from clk100: phi0, non-overlapping phi1/phi2,
//   the 4x phase clock fphi0, phi2 edge strobes for clk100-domain logic, and
//   a locked flag. All outputs are registered; each register is loaded with
//   the decode of the count it will hold next, so outputs and count always
//   agree within a cycle. Downstream fabric should use the strobes, not clock
//   on the derived phases.
//
// Ports
//   clk100     in   system clock (the only clock)
//   RST        in   synchronous active-high reset
//   stretch    in   hold phi0/phi2 high; sampled only at cnt == H-1
//   fphi0      out  fast phase clock, period DIV/4
//   phi0       out  CPU master phase
//   phi1       out  inverted phase, non-overlapping with phi2
//   phi2       out  delayed phase, non-overlapping with phi1
//   phi2_rise  out  one-cycle strobe in the cycle phi2 becomes 1
//   phi2_fall  out  one-cycle strobe in the cycle phi2 becomes 0
//   locked     out  phases stable and valid
// -----------------------------------------------------------------------------
module clk_phase_gen
  import clk_phase_pkg::*;
#(
  parameter int unsigned DIV          = DIV_DEFAULT,
  parameter int unsigned NONOVL       = NONOVL_DEFAULT,
  parameter int unsigned LOCK_PERIODS = LOCK_PERIODS_DEFAULT
) (
  input  logic clk100,
  input  logic RST,
  input  logic stretch,
  output logic fphi0,
  output logic phi0,
  output logic phi1,
  output logic phi2,
  output logic phi2_rise,
  output logic phi2_fall,
  output logic locked
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST_C   = CW'(DIV - 32'd1);
  localparam logic [CW-1:0] H_C      = CW'(DIV / 32'd2);
  localparam logic [CW-1:0] HM1_C    = CW'((DIV / 32'd2) - 32'd1);
  localparam logic [CW-1:0] NONOVL_C = CW'(NONOVL);

  if (((DIV % 32'd4) != 32'd0) || (DIV < 32'd8)) begin : g_bad_div
    $error("clk_phase_gen: DIV must be a multiple of 4 and at least 8");
  end
  if ((NONOVL < 32'd1) || (NONOVL > ((DIV / 32'd4) - 32'd1))) begin : g_bad_nonovl
    $error("clk_phase_gen: NONOVL must be in 1 .. DIV/4-1");
  end

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          run_r;   // 0 in reset cycles: the exit into cnt = 0 is not a wrap
  logic          hold_s;
  logic          wrap_s;
  phase_t        dec_s;

  assign hold_s = (cnt_r == HM1_C) && stretch;
  assign wrap_s = (cnt_r >= LAST_C) && run_r && !RST;

  // Next count: hold at H-1 while stretched, wrap after DIV-1, else advance.
  // Out-of-range values (upset) also fold back to 0.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (hold_s) begin
      cnt_nxt_s = cnt_r;
    end else if (cnt_r >= LAST_C) begin
      cnt_nxt_s = {CW{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
  end

  // Phase levels for the count about to be loaded.
  always_comb begin
    dec_s = phase_decode(32'(cnt_nxt_s), DIV, NONOVL);
  end

  // Counter and registered outputs; reset parks the counter at DIV-1 so the
  // first cycle after release starts a fresh period at cnt = 0.
  always_ff @(posedge clk100) begin
    if (RST) begin
      cnt_r     <= LAST_C;
      run_r     <= 1'b0;
      phi0      <= 1'b0;
      phi1      <= 1'b0;
      phi2      <= 1'b0;
      fphi0     <= 1'b0;
      phi2_rise <= 1'b0;
      phi2_fall <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      run_r     <= 1'b1;
      phi0      <= dec_s.phi0;
      phi1      <= dec_s.phi1;
      phi2      <= dec_s.phi2;
      fphi0     <= dec_s.fphi0;
      // NONOVL < H-1, so the count can never be held on the rise position.
      phi2_rise <= (cnt_nxt_s == NONOVL_C);
      phi2_fall <= (cnt_nxt_s == H_C) && !hold_s;
    end
  end

  clk_phase_lock_ctr #(
    .LOCK_PERIODS(LOCK_PERIODS)
  ) u_lock (
    .clk100(clk100),
    .rst   (RST),
    .wrap  (wrap_s),
    .locked(locked)
  );

endmodule

// File: tb/tb_clk_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_phase_gen
//   Directed bench for clk_phase_gen with default parameters
//   (DIV = 56, H = 28, Q = 14, NONOVL = 2, LOCK_PERIODS = 4).
//   Output vector order: {phi0, phi1, phi2, fphi0, phi2_rise, phi2_fall, locked}.
// -----------------------------------------------------------------------------
module tb_clk_phase_gen;
  import clk_phase_pkg::*;

  localparam int unsigned DIV    = DIV_DEFAULT;
  localparam int unsigned NONOVL = NONOVL_DEFAULT;

  logic clk100 = 1'b0;
  logic RST;
  logic stretch;
  logic fphi0, phi0, phi1, phi2, phi2_rise, phi2_fall, locked;

  int checks = 0;
  int errors = 0;
  int t      = 0;   // cycle index relative to the latest reset release

  clk_phase_gen #(
    .DIV(DIV_DEFAULT),
    .NONOVL(NONOVL_DEFAULT),
    .LOCK_PERIODS(LOCK_PERIODS_DEFAULT)
  ) dut (
    .clk100   (clk100),
    .RST      (RST),
    .stretch  (stretch),
    .fphi0    (fphi0),
    .phi0     (phi0),
    .phi1     (phi1),
    .phi2     (phi2),
    .phi2_rise(phi2_rise),
    .phi2_fall(phi2_fall),
    .locked   (locked)
  );

  always #5 clk100 = ~clk100;

  typedef struct {
    int         cyc;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [6:0] outs();
    return {phi0, phi1, phi2, fphi0, phi2_rise, phi2_fall, locked};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0b, expected %0b", name, t, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk100);
    #1;
    t++;
  endtask

  initial begin
    phase_t     p;
    int         cnt_m;
    int         last_rise;
    int         fr;
    logic       prev_phi0;
    logic       prev_f;

    // Hand-computed waveform points after reset release, stretch = 0.
    vecs[0]  = '{0,   7'b1001000};
    vecs[1]  = '{1,   7'b1001000};
    vecs[2]  = '{2,   7'b1011100};
    vecs[3]  = '{3,   7'b1011000};
    vecs[4]  = '{7,   7'b1010000};
    vecs[5]  = '{14,  7'b1011000};
    vecs[6]  = '{27,  7'b1010000};
    vecs[7]  = '{28,  7'b0001010};
    vecs[8]  = '{29,  7'b0001000};
    vecs[9]  = '{30,  7'b0101000};
    vecs[10] = '{35,  7'b0100000};
    vecs[11] = '{55,  7'b0100000};
    vecs[12] = '{56,  7'b1001000};
    vecs[13] = '{58,  7'b1011100};
    vecs[14] = '{59,  7'b1011000};
    vecs[15] = '{84,  7'b0001010};
    vecs[16] = '{223, 7'b0100000};
    vecs[17] = '{224, 7'b1001001};
    vecs[18] = '{226, 7'b1011101};

    // Reset state.
    RST     = 1'b1;
    stretch = 1'b0;
    repeat (3) @(posedge clk100);
    #1;
    check("reset_outputs", 32'(outs()), 32'd0);

    // Release and walk the vector table.
    RST = 1'b0;
    @(posedge clk100);
    #1;
    t = 0;
    foreach (vecs[i]) begin
      while (t < vecs[i].cyc) step();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Mid-period reset at cycle 300 (cnt = 20).
    while (t < 300) step();
    RST = 1'b1;
    step();
    check("mid_reset_outputs", 32'(outs()), 32'd0);
    step();
    RST = 1'b0;
    step();
    t = 0;
    check("reset_exit_cycle0", 32'(outs()), 32'b1001000);
    while (!locked && t < 600) step();
    check("relock_cycle", 32'(t), 32'd224);
    check("relock_outputs", 32'(outs()), 32'b1001001);

    // Stretch held for 10 cycles starting at cnt = 27 (cycle 251).
    while (t < 251) step();
    check("pre_stretch", 32'(outs()), 32'b1010001);
    stretch = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 9) stretch = 1'b0;
      check("stretch_hold", 32'(outs()), 32'b1010001);
    end
    step();
    check("stretch_release_fall", 32'(outs()), 32'b0001011);
    step();
    check("fall_one_cycle", 32'(outs()), 32'b0001001);
    while (!phi0 && t < 500) step();
    check("stretch_period", 32'(t - 224), 32'd66);

    // 1000 periods with random stretch everywhere except cnt = 27.
    cnt_m     = 0;
    last_rise = t;
    fr        = 0;
    prev_phi0 = phi0;
    for (int n = 0; n < 1000 * 56; n++) begin
      stretch = (cnt_m == 27) ? 1'b0 : 1'($urandom_range(0, 1));
      prev_f  = fphi0;
      step();
      cnt_m = (cnt_m == 55) ? 0 : cnt_m + 1;
      p = phase_decode(cnt_m, DIV, NONOVL);
      check("model", 32'(outs()),
            32'({p.phi0, p.phi1, p.phi2, p.fphi0, 1'(cnt_m == 2), 1'(cnt_m == 28), 1'b1}));
      check("no_overlap", 32'(phi1 & phi2), 32'd0);
      if (fphi0 && !prev_f) fr++;
      if (phi0 && !prev_phi0) begin
        check("period_56", 32'(t - last_rise), 32'd56);
        check("fphi0_rises", 32'(fr), 32'd4);
        check("fphi0_with_phi0", 32'(fphi0), 32'd1);
        fr        = 0;
        last_rise = t;
      end
      prev_phi0 = phi0;
    end
    stretch = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
